// File: rtl/chol_seq_pkg.sv
// Shared constants and types for the Cholesky load/sequence/unload controller.
package chol_pkg;
  localparam int N     = 6;
  localparam int W     = 16;
  localparam int IDX_W = $clog2(N*N);
  localparam int RC_W  = $clog2(N);

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_SQRT = 2'd1;
  localparam logic [1:0] MODE_DIV  = 2'd2;
  localparam logic [1:0] MODE_UPD  = 2'd3;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SQRT,
    ST_DIV,
    ST_UPD,
    ST_DRAIN
  } chol_state_t;

  typedef logic [N*N-1:0][W-1:0] mat_t;

  function automatic logic [IDX_W-1:0] flat_idx(input logic [RC_W-1:0] r,
                                                input logic [RC_W-1:0] c);
    return IDX_W'(r) * IDX_W'(N) + IDX_W'(c);
  endfunction
endpackage

// File: rtl/chol_seq_if.sv
// Word-stream handshake bundle: matrix in, factor out. master = environment, slave = chol_seq.
interface chol_seq_if;
  import chol_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/chol_seq_step_timer.sv
// Loadable down-counter timing the sqrt/update dwell; expire is a decode of the count, no latency.
// No backpressure: load wins over count, count holds at zero.
module chol_step_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          count,
  output logic          expire
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/chol_seq.sv
// Loads a 6x6 matrix, sequences the Cholesky datapath per column, drains the factor; all outputs registered.
// out_valid/out_data hold under out_ready=0; CHOL_SEQ_FULL_OUT_EN drains all 36 words (upper zeroed).
module chol_seq
  import chol_pkg::*;
#(
  parameter int SQRT_LAT = 8,
  parameter int UPD_CYC  = 4
) (
  input  logic             clk,
  input  logic             reset,
  chol_seq_if.slave        io,
  output logic             busy,
  output logic [1:0]       mode,
  output logic [RC_W-1:0]  column,
  output mat_t             a,
  input  mat_t             lt
);
  localparam int               TW       = 8;
  localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(N-1);
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N*N-1);

  chol_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [RC_W-1:0]  row, col;
  logic             rdy_q, ov_q, ol_q;
  logic [W-1:0]     od_q;

  logic             t_load, t_count, t_expire;
  logic [TW-1:0]    t_val;

  logic [RC_W-1:0]  nxt_r, nxt_c;
  logic             nxt_last;
  logic [W-1:0]     nxt_dat;

  // Reset gates in_ready directly so nothing is accepted while reset is held.
  assign io.in_ready  = rdy_q & ~reset;
  assign io.out_valid = ov_q;
  assign io.out_data  = od_q;
  assign io.out_last  = ol_q;

  always_comb begin
    t_load = 1'b0;
    t_val  = TW'(SQRT_LAT-1);
    case (state)
      ST_LOAD: t_load = io.in_valid && (idx == LAST_IDX);
      ST_DIV: begin
        t_load = (column != LAST_RC);
        t_val  = TW'(UPD_CYC-1);
      end
      ST_UPD:  t_load = t_expire;
      default: t_load = 1'b0;
    endcase
  end

  assign t_count = (state == ST_SQRT) || (state == ST_UPD);

  chol_step_timer #(.CW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .count    (t_count),
    .expire   (t_expire)
  );

  // Next drain position; the word is pre-registered so a stall never changes out_data.
  always_comb begin
    nxt_r = row;
    nxt_c = col + RC_ONE;
`ifdef CHOL_SEQ_FULL_OUT_EN
    if (col == LAST_RC) begin
      nxt_r = row + RC_ONE;
      nxt_c = '0;
    end
`else
    if (col == row) begin
      nxt_r = row + RC_ONE;
      nxt_c = '0;
    end
`endif
    nxt_last = (nxt_r == LAST_RC) && (nxt_c == LAST_RC);
    nxt_dat  = lt[flat_idx(nxt_r, nxt_c)];
`ifdef CHOL_SEQ_FULL_OUT_EN
    if (nxt_c > nxt_r) nxt_dat = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_LOAD;
      rdy_q  <= 1'b1;
      mode   <= MODE_IDLE;
      column <= '0;
      busy   <= 1'b0;
      a      <= '0;
      idx    <= '0;
      row    <= '0;
      col    <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      ol_q   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (io.in_valid) begin
            a[idx] <= io.in_data;
            if (idx == LAST_IDX) begin
              idx    <= '0;
              rdy_q  <= 1'b0;
              state  <= ST_SQRT;
              mode   <= MODE_SQRT;
              busy   <= 1'b1;
              column <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_SQRT: begin
          if (t_expire) begin
            state <= ST_DIV;
            mode  <= MODE_DIV;
          end
        end
        ST_DIV: begin
          if (column != LAST_RC) begin
            state <= ST_UPD;
            mode  <= MODE_UPD;
          end else begin
            state <= ST_DRAIN;
            mode  <= MODE_IDLE;
            busy  <= 1'b0;
            ov_q  <= 1'b1;
            od_q  <= lt[0];
            ol_q  <= 1'b0;
            row   <= '0;
            col   <= '0;
          end
        end
        ST_UPD: begin
          if (t_expire) begin
            state  <= ST_SQRT;
            mode   <= MODE_SQRT;
            column <= column + RC_ONE;
          end
        end
        ST_DRAIN: begin
          if (io.out_ready) begin
            if (ol_q) begin
              ov_q   <= 1'b0;
              ol_q   <= 1'b0;
              od_q   <= '0;
              row    <= '0;
              col    <= '0;
              column <= '0;
              rdy_q  <= 1'b1;
              state  <= ST_LOAD;
            end else begin
              row  <= nxt_r;
              col  <= nxt_c;
              od_q <= nxt_dat;
              ol_q <= nxt_last;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end
endmodule
